ht_cmd_hazard_guard: RTL and testbench
======================================

# ht_cmd_hazard_guard

Upstream admission stage for `hash_table_top`: accepts hash-table commands from the command source and forwards them unchanged. It holds back any command whose key is already in flight, meaning issued and its result not yet observed. This keeps at most one operation per key inside the table pipeline, so INSERT/DELETE/SEARCH sequences on the same key complete strictly in issue order. It observes the result handshake on the table's output to retire in-flight keys.

## Interface
Parameters:
- `KEY_WIDTH` — 32 — key width; matches hash_table package.
- `VALUE_WIDTH` — 16 — value width.
- `OPCODE_WIDTH` — 2 — opcode width (OP_SEARCH/OP_INSERT/OP_DELETE passed through opaque).
- `MAX_INFLIGHT` — 8 — in-flight key table depth (≥2).

Ports:
- `clk_i` in 1 — single clock.
- `rst_i` in 1 — asynchronous reset, active-high.
- `cmd_in_valid` in 1 — upstream command valid.
- `cmd_in_ready` out 1 — guard accepts command this cycle.
- `cmd_in_key` / `cmd_in_value` / `cmd_in_opcode` in KEY_WIDTH / VALUE_WIDTH / OPCODE_WIDTH — command fields.
- `cmd_out_valid` out 1 — command to hash_table_top valid.
- `cmd_out_ready` in 1 — hash_table_top ready.
- `cmd_out_key` / `cmd_out_value` / `cmd_out_opcode` out — registered command fields.
- `res_tap_valid` in 1 — result handshake completed, i.e. ht_res_out valid & ready.
- `res_tap_key` in KEY_WIDTH — key of the completed result.
- `inflight_cnt_o` out $clog2(MAX_INFLIGHT+1) — occupied table entries.
- `hazard_stall_o` out 1 — cycle flag: input valid but blocked by key match.
- `orphan_o` out 1 — one-cycle pulse: retire key matched no entry.

## Operation
- **Key table.** MAX_INFLIGHT entries of {vld, key}. Allocation takes the lowest-index free entry. Invariant: no two valid entries hold the same key.
- **Output stage.** A single register holds {valid, key, value, opcode}. It is "free" when empty, or when `cmd_out_valid & cmd_out_ready` this cycle.
- **Hit.** `hit` = any valid entry whose key equals `cmd_in_key`. The comparison uses registered table contents, before this cycle's retire.
- **Ready.** `cmd_in_ready` = !rst_i & output free & inflight_cnt_o < MAX_INFLIGHT & !hit. It may depend on `cmd_in_key` but never on `cmd_in_valid`.
- **Accept** (`cmd_in_valid & cmd_in_ready`):
  - the command is loaded into the output register;
  - the key is allocated in the table at the same edge.
  - A key therefore counts as in flight while it sits in the output register.
- **Retire** (`res_tap_valid`): the matching valid entry is cleared at the next edge. With no match, the table is unchanged and `orphan_o` pulses for 1 cycle on the next edge.
- **Counter.** inflight_cnt_o is +1 on accept, −1 on matched retire, and unchanged when both occur in the same cycle.
- **Stall flag.** hazard_stall_o = cmd_in_valid & hit (combinational).
- **Opcode.** Ignored for hazard purposes; all same-key commands serialize, including SEARCH after SEARCH.

## Timing
- **Reset.** While rst_i is high, asynchronously:
  - cmd_out_valid = 0 and cmd_out_key/value/opcode = 0;
  - all table entries invalid;
  - inflight_cnt_o = 0, orphan_o = 0;
  - cmd_in_ready = 0.
- **Mid-operation reset.** Discards all in-flight state. Results arriving later are treated as orphans.
- **Latency.** Accepted in cycle N → cmd_out_valid in N+1. Full throughput is 1 command/cycle with distinct keys and cmd_out_ready held high.
- **Backpressure.** While cmd_out_valid & !cmd_out_ready:
  - output fields are held stable;
  - cmd_in_ready = 0.
- **Same-cycle retire and request on the same key.** The request stalls that cycle and is accepted the next cycle (earliest).
- **Same-cycle retire and request on different keys.** Both proceed.
- **Full table.** cmd_in_ready = 0 until a retire. The entry freed at edge E is reusable by an accept in the cycle after E.
- **Accept and retire together.** Allocation excludes the entry being retired in the same cycle.

## Test plan
- **Distinct keys.** Reset, then 4 back-to-back commands with keys 0x01000000..0x01000003 and cmd_out_ready=1 → cmd_out_valid cycles 1–4 after first accept; inflight_cnt_o reaches 4; no stall.
- **Same-key hazard.** INSERT 0x01000000/0x1234, then SEARCH 0x01000000:
  - SEARCH holds with hazard_stall_o=1 until the res_tap_valid for 0x01000000;
  - SEARCH is accepted the cycle after the retire cycle;
  - DELETE 0x01000001 issued behind it is not reordered ahead.
- **Full table.** 8 distinct keys with no results → cmd_in_ready=0 on the 9th. Retire key #3 → 9th accepted the following cycle; inflight_cnt_o=8.
- **Backpressure.** cmd_out_ready=0 for 5 cycles → output key/value/opcode stable, cmd_in_ready=0. Release → drains, next command accepted the same cycle.
- **Orphan retire.** res_tap_valid with key 0xDEADBEEF, no entry → orphan_o single pulse; inflight_cnt_o unchanged.
- **Mid-traffic reset.** Assert rst_i with 3 in flight → all outputs 0 immediately. After release, a previously in-flight key is accepted without stall.

Source files
------------

// File: rtl/ht_cmd_hazard_guard.sv
// Admission guard for hash_table_top: forwards commands unchanged but holds any whose key is still in flight.
// Latency: 1 cycle from accept to cmd_out_valid (registered output stage); full throughput with distinct keys.
// Backpressure: cmd_in_ready drops on output stall, full key table, or a key hit (independent of cmd_in_valid).
module ht_cmd_hazard_guard #(
    parameter int KEY_WIDTH    = 32,
    parameter int VALUE_WIDTH  = 16,
    parameter int OPCODE_WIDTH = 2,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                cmd_in_valid,
    output logic                                cmd_in_ready,
    input  logic [KEY_WIDTH-1:0]                cmd_in_key,
    input  logic [VALUE_WIDTH-1:0]              cmd_in_value,
    input  logic [OPCODE_WIDTH-1:0]             cmd_in_opcode,
    output logic                                cmd_out_valid,
    input  logic                                cmd_out_ready,
    output logic [KEY_WIDTH-1:0]                cmd_out_key,
    output logic [VALUE_WIDTH-1:0]              cmd_out_value,
    output logic [OPCODE_WIDTH-1:0]             cmd_out_opcode,
    input  logic                                res_tap_valid,
    input  logic [KEY_WIDTH-1:0]                res_tap_key,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_cnt_o,
    output logic                                hazard_stall_o,
    output logic                                orphan_o
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    // In-flight key table
    logic [MAX_INFLIGHT-1:0] vld_q;
    logic [KEY_WIDTH-1:0]    key_q [MAX_INFLIGHT];

    // Output stage
    logic                    out_vld_q;
    logic [KEY_WIDTH-1:0]    out_key_q;
    logic [VALUE_WIDTH-1:0]  out_val_q;
    logic [OPCODE_WIDTH-1:0] out_op_q;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    orphan_q;

    logic                    hit;
    logic [MAX_INFLIGHT-1:0] ret_hit;
    logic [MAX_INFLIGHT-1:0] alloc_oh;
    logic                    alloc_taken;
    logic                    out_free;
    logic                    accept;
    logic                    ret_match;

    // Key lookups against registered table: request hit, retire match, lowest free slot.
    // The free-slot search uses registered valid bits, so a slot retiring this cycle is never reallocated in the same cycle.
    always_comb begin
        hit         = 1'b0;
        ret_hit     = '0;
        alloc_oh    = '0;
        alloc_taken = 1'b0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            if (vld_q[i] && (key_q[i] == cmd_in_key)) begin
                hit = 1'b1;
            end
            if (vld_q[i] && (key_q[i] == res_tap_key)) begin
                ret_hit[i] = 1'b1;
            end
            if (!vld_q[i] && !alloc_taken) begin
                alloc_oh[i] = 1'b1;
                alloc_taken = 1'b1;
            end
        end
    end

    assign out_free     = !out_vld_q || cmd_out_ready;
    assign cmd_in_ready = !rst_i && out_free && (cnt_q < MAX_CNT) && !hit;
    assign accept       = cmd_in_valid && cmd_in_ready;
    assign ret_match    = res_tap_valid && (|ret_hit);

    // Accept and matched retire in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, accept} - {{(CNT_W-1){1'b0}}, ret_match};
    end

    // Table update: allocate on accept, clear matched entry on retire (never the same slot).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                if (accept && alloc_oh[i]) begin
                    vld_q[i] <= 1'b1;
                    key_q[i] <= cmd_in_key;
                end else if (res_tap_valid && ret_hit[i]) begin
                    vld_q[i] <= 1'b0;
                end
            end
        end
    end

    // Output register: load on accept, empty when drained, hold fields under backpressure.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_vld_q <= 1'b0;
            out_key_q <= '0;
            out_val_q <= '0;
            out_op_q  <= '0;
        end else if (accept) begin
            out_vld_q <= 1'b1;
            out_key_q <= cmd_in_key;
            out_val_q <= cmd_in_value;
            out_op_q  <= cmd_in_opcode;
        end else if (cmd_out_ready) begin
            out_vld_q <= 1'b0;
        end
    end

    // Occupancy counter and one-cycle orphan pulse for retires that matched nothing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            orphan_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            orphan_q <= res_tap_valid && !(|ret_hit);
        end
    end

    assign cmd_out_valid  = out_vld_q;
    assign cmd_out_key    = out_key_q;
    assign cmd_out_value  = out_val_q;
    assign cmd_out_opcode = out_op_q;
    assign inflight_cnt_o = cnt_q;
    assign hazard_stall_o = cmd_in_valid && hit;
    assign orphan_o       = orphan_q;

endmodule

// File: tb/tb_ht_cmd_hazard_guard.sv
// Directed bench for ht_cmd_hazard_guard with an output-side scoreboard.
// Inputs change 1ns after posedge; outputs are sampled on negedge or 1ns after posedge.
// Expected outputs are queued when commands are issued; the monitor pops on each output handshake.
module tb_ht_cmd_hazard_guard;

    localparam int KW = 32;
    localparam int VW = 16;
    localparam int OW = 2;
    localparam int MI = 8;
    localparam int CW = $clog2(MI + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_in_valid;
    logic          cmd_in_ready;
    logic [KW-1:0] cmd_in_key;
    logic [VW-1:0] cmd_in_value;
    logic [OW-1:0] cmd_in_opcode;
    logic          cmd_out_valid;
    logic          cmd_out_ready;
    logic [KW-1:0] cmd_out_key;
    logic [VW-1:0] cmd_out_value;
    logic [OW-1:0] cmd_out_opcode;
    logic          res_tap_valid;
    logic [KW-1:0] res_tap_key;
    logic [CW-1:0] inflight_cnt;
    logic          hazard_stall;
    logic          orphan;

    typedef struct packed {
        logic [KW-1:0] key;
        logic [VW-1:0] val;
        logic [OW-1:0] op;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   waited;
    logic stall0;

    always #5 clk = ~clk;

    ht_cmd_hazard_guard #(
        .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .OPCODE_WIDTH(OW), .MAX_INFLIGHT(MI)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cmd_in_valid   (cmd_in_valid),
        .cmd_in_ready   (cmd_in_ready),
        .cmd_in_key     (cmd_in_key),
        .cmd_in_value   (cmd_in_value),
        .cmd_in_opcode  (cmd_in_opcode),
        .cmd_out_valid  (cmd_out_valid),
        .cmd_out_ready  (cmd_out_ready),
        .cmd_out_key    (cmd_out_key),
        .cmd_out_value  (cmd_out_value),
        .cmd_out_opcode (cmd_out_opcode),
        .res_tap_valid  (res_tap_valid),
        .res_tap_key    (res_tap_key),
        .inflight_cnt_o (inflight_cnt),
        .hazard_stall_o (hazard_stall),
        .orphan_o       (orphan)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [KW-1:0] k, input logic [VW-1:0] v, input logic [OW-1:0] op);
        cmd_t c;
        c.key = k;
        c.val = v;
        c.op  = op;
        exp_q.push_back(c);
    endtask

    // Issue one command and wait (bounded) for acceptance; reports cycles waited and first-cycle stall flag.
    task automatic send(input logic [KW-1:0] k, input logic [VW-1:0] v, input logic [OW-1:0] op,
                        output int n, output logic st0);
        push_exp(k, v, op);
        cmd_in_valid  = 1'b1;
        cmd_in_key    = k;
        cmd_in_value  = v;
        cmd_in_opcode = op;
        n   = 0;
        st0 = 1'b0;
        forever begin
            @(negedge clk);
            if (n == 0) st0 = hazard_stall;
            if (cmd_in_ready) break;
            n++;
            if (n > 100) break;
        end
        if (n > 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: key %h not accepted after %0d cycles, expected acceptance", k, n);
            exp_q.delete(exp_q.size() - 1);
        end
        tick();
        cmd_in_valid = 1'b0;
    endtask

    task automatic retire(input logic [KW-1:0] k);
        res_tap_valid = 1'b1;
        res_tap_key   = k;
        tick();
        res_tap_valid = 1'b0;
    endtask

    // Scoreboard monitor: every output handshake must match the oldest expected command.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && cmd_out_valid && cmd_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got key %h, expected no output", cmd_out_key);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_key", 64'(cmd_out_key), 64'(mon_e.key));
                    chk("out_value", 64'(cmd_out_value), 64'(mon_e.val));
                    chk("out_opcode", 64'(cmd_out_opcode), 64'(mon_e.op));
                end
            end
        end
    end

    initial begin
        rst           = 1'b0;
        cmd_in_valid  = 1'b0;
        cmd_in_key    = '0;
        cmd_in_value  = '0;
        cmd_in_opcode = '0;
        cmd_out_ready = 1'b1;
        res_tap_valid = 1'b0;
        res_tap_key   = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(cmd_out_valid), 0);
        chk("rst_in_ready", 64'(cmd_in_ready), 0);
        chk("rst_cnt", 64'(inflight_cnt), 0);
        chk("rst_orphan", 64'(orphan), 0);
        tick();
        tick();
        rst = 1'b0;

        // Distinct keys, back to back
        for (int i = 0; i < 4; i++) begin
            send(32'h0100_0000 + 32'(i), 16'h1000 + 16'(i), 2'd1, waited, stall0);
            chk("dk_wait", 64'(waited), 0);
            chk("dk_stall", 64'(stall0), 0);
            chk("dk_out_valid", 64'(cmd_out_valid), 1);
            chk("dk_out_key", 64'(cmd_out_key), 64'(32'h0100_0000 + 32'(i)));
        end
        chk("dk_cnt4", 64'(inflight_cnt), 4);
        for (int i = 0; i < 4; i++) retire(32'h0100_0000 + 32'(i));
        chk("dk_cnt0", 64'(inflight_cnt), 0);
        chk("dk_orphan", 64'(orphan), 0);

        // Same-key hazard: INSERT then SEARCH on same key, DELETE of another key behind it
        send(32'h0100_0000, 16'h1234, 2'd1, waited, stall0);
        chk("hz_ins_wait", 64'(waited), 0);
        push_exp(32'h0100_0000, 16'h0000, 2'd0);
        cmd_in_valid  = 1'b1;
        cmd_in_key    = 32'h0100_0000;
        cmd_in_value  = 16'h0000;
        cmd_in_opcode = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hz_stall", 64'(hazard_stall), 1);
            chk("hz_ready", 64'(cmd_in_ready), 0);
            tick();
        end
        res_tap_valid = 1'b1;
        res_tap_key   = 32'h0100_0000;
        @(negedge clk);
        chk("hz_retire_cycle_stall", 64'(hazard_stall), 1);
        chk("hz_retire_cycle_ready", 64'(cmd_in_ready), 0);
        tick();
        res_tap_valid = 1'b0;
        @(negedge clk);
        chk("hz_after_stall", 64'(hazard_stall), 0);
        chk("hz_after_ready", 64'(cmd_in_ready), 1);
        tick();
        cmd_in_valid = 1'b0;
        chk("hz_cnt", 64'(inflight_cnt), 1);
        chk("hz_orphan", 64'(orphan), 0);
        chk("hz_out_op", 64'(cmd_out_opcode), 0);
        send(32'h0100_0001, 16'h0000, 2'd2, waited, stall0);
        chk("hz_del_wait", 64'(waited), 0);
        chk("hz_cnt2", 64'(inflight_cnt), 2);
        retire(32'h0100_0000);
        retire(32'h0100_0001);
        chk("hz_cnt0", 64'(inflight_cnt), 0);

        // Full table
        for (int i = 0; i < 8; i++) begin
            send(32'h0200_0000 + 32'(i), 16'h2000 + 16'(i), 2'd1, waited, stall0);
            chk("full_fill_wait", 64'(waited), 0);
        end
        chk("full_cnt8", 64'(inflight_cnt), 8);
        push_exp(32'h0200_0008, 16'h2008, 2'd1);
        cmd_in_valid  = 1'b1;
        cmd_in_key    = 32'h0200_0008;
        cmd_in_value  = 16'h2008;
        cmd_in_opcode = 2'd1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("full_ready", 64'(cmd_in_ready), 0);
            chk("full_stall", 64'(hazard_stall), 0);
            tick();
        end
        res_tap_valid = 1'b1;
        res_tap_key   = 32'h0200_0003;
        @(negedge clk);
        chk("full_retire_cycle_ready", 64'(cmd_in_ready), 0);
        tick();
        res_tap_valid = 1'b0;
        chk("full_cnt7", 64'(inflight_cnt), 7);
        @(negedge clk);
        chk("full_reuse_ready", 64'(cmd_in_ready), 1);
        tick();
        cmd_in_valid = 1'b0;
        chk("full_cnt_again8", 64'(inflight_cnt), 8);
        for (int i = 0; i < 9; i++) begin
            if (i != 3) retire(32'h0200_0000 + 32'(i));
        end
        chk("full_cnt0", 64'(inflight_cnt), 0);

        // Backpressure
        cmd_out_ready = 1'b0;
        send(32'h0300_0000, 16'hAAAA, 2'd1, waited, stall0);
        chk("bp_a_wait", 64'(waited), 0);
        push_exp(32'h0300_0001, 16'hBBBB, 2'd2);
        cmd_in_valid  = 1'b1;
        cmd_in_key    = 32'h0300_0001;
        cmd_in_value  = 16'hBBBB;
        cmd_in_opcode = 2'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(cmd_out_valid), 1);
            chk("bp_key", 64'(cmd_out_key), 64'h0300_0000);
            chk("bp_value", 64'(cmd_out_value), 64'hAAAA);
            chk("bp_opcode", 64'(cmd_out_opcode), 1);
            chk("bp_in_ready", 64'(cmd_in_ready), 0);
            tick();
        end
        cmd_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(cmd_in_ready), 1);
        tick();
        cmd_in_valid = 1'b0;
        chk("bp_next_key", 64'(cmd_out_key), 64'h0300_0001);
        chk("bp_cnt2", 64'(inflight_cnt), 2);
        retire(32'h0300_0000);
        retire(32'h0300_0001);

        // Orphan retire
        send(32'h0400_0000, 16'h4444, 2'd0, waited, stall0);
        chk("orph_cnt1", 64'(inflight_cnt), 1);
        retire(32'hDEAD_BEEF);
        chk("orph_pulse", 64'(orphan), 1);
        chk("orph_cnt", 64'(inflight_cnt), 1);
        tick();
        chk("orph_pulse_end", 64'(orphan), 0);
        retire(32'h0400_0000);
        chk("orph_match", 64'(orphan), 0);
        chk("orph_cnt0", 64'(inflight_cnt), 0);

        // Mid-traffic reset with 3 in flight, the last stuck in the output register
        send(32'h0500_0000, 16'h5000, 2'd1, waited, stall0);
        send(32'h0500_0001, 16'h5001, 2'd1, waited, stall0);
        tick();
        cmd_out_ready = 1'b0;
        send(32'h0500_0002, 16'h5002, 2'd1, waited, stall0);
        chk("mr_cnt3", 64'(inflight_cnt), 3);
        chk("mr_held_valid", 64'(cmd_out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_out_valid", 64'(cmd_out_valid), 0);
        chk("mr_out_key", 64'(cmd_out_key), 0);
        chk("mr_out_value", 64'(cmd_out_value), 0);
        chk("mr_out_opcode", 64'(cmd_out_opcode), 0);
        chk("mr_cnt", 64'(inflight_cnt), 0);
        chk("mr_in_ready", 64'(cmd_in_ready), 0);
        chk("mr_orphan", 64'(orphan), 0);
        chk("mr_pending", 64'(exp_q.size()), 1);
        exp_q.delete();
        tick();
        tick();
        rst           = 1'b0;
        cmd_out_ready = 1'b1;
        retire(32'h0500_0000);
        chk("mr_late_orphan", 64'(orphan), 1);
        chk("mr_late_cnt", 64'(inflight_cnt), 0);
        send(32'h0500_0001, 16'h5101, 2'd0, waited, stall0);
        chk("mr_reissue_wait", 64'(waited), 0);
        chk("mr_reissue_stall", 64'(stall0), 0);
        chk("mr_reissue_cnt", 64'(inflight_cnt), 1);
        retire(32'h0500_0001);
        chk("mr_final_cnt", 64'(inflight_cnt), 0);

        // Let the scoreboard drain
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_empty", 64'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
